// File: rtl/friet_ae_arb_pkg.sv
// friet_ae_arb_pkg: shared state encoding and widths for the Friet AE stream arbiter.
package friet_ae_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DRAIN = 2'd2} arb_state_e;
    localparam int LEN_W_DEFAULT = 16;
    localparam int STATS_W = 16;
endpackage

// File: rtl/friet_rr_arbiter.sv
// friet_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module friet_rr_arbiter #(
    parameter int N = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[IW'((int'(ptr) + k) % N)]) idx = IW'((int'(ptr) + k) % N);
        gnt = |req ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/friet_ae_stream_arbiter.sv
// friet_ae_stream_arbiter: round-robin transaction arbiter sharing one Friet AE 8-bit core.
// Define FRIET_ARB_STATS_EN to add per-requester completed-transaction counters (txn_count).
module friet_ae_stream_arbiter
    import friet_ae_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = LEN_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic [NUM_REQ*8-1:0]     req_din,
    input  logic [NUM_REQ-1:0]       req_din_valid,
    input  logic [NUM_REQ-1:0]       req_din_last,
    output logic [NUM_REQ-1:0]       req_din_ready,
    input  logic [NUM_REQ*LEN_W-1:0] req_rsp_len,
    output logic [7:0]               req_dout,
    output logic [NUM_REQ-1:0]       req_dout_valid,
    input  logic [NUM_REQ-1:0]       req_dout_ready,
    output logic [7:0]               core_din,
    output logic                     core_din_valid,
    input  logic                     core_din_ready,
    input  logic [7:0]               core_dout,
    input  logic                     core_dout_valid,
    output logic                     core_dout_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     err_stray_dout
`ifdef FRIET_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0] txn_count
`endif
);
    localparam int IW = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, arb_gnt;
    logic [IW-1:0]      gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, arb_idx;
    logic [LEN_W-1:0]   rsp_cnt_q, rsp_cnt_d, cnt_dec;
    logic               err_q, err_d, in_open, out_open, in_last, done;

    friet_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req(req_din_valid), .ptr(rr_ptr_q), .gnt(arb_gnt), .idx(arb_idx)
    );

    always_comb begin
        in_open         = state_q == FWD;
        out_open        = state_q == FWD || state_q == DRAIN;
        core_din        = req_din[gidx_q*8 +: 8];
        core_din_valid  = in_open & req_din_valid[gidx_q];
        req_din_ready   = (in_open & core_din_ready) ? grant_q : '0;
        req_dout        = core_dout;
        req_dout_valid  = (out_open & core_dout_valid) ? grant_q : '0;
        core_dout_ready = out_open & req_dout_ready[gidx_q];
        in_last         = core_din_valid & core_din_ready & req_din_last[gidx_q];
        // The core emits beats regardless of ready, so count every valid beat.
        cnt_dec         = (core_dout_valid && rsp_cnt_q != '0) ? rsp_cnt_q - 1'b1 : rsp_cnt_q;
        done            = cnt_dec == '0 && ((in_open && in_last) || state_q == DRAIN);
        err_d           = err_q | (core_dout_valid & (!out_open | (in_open & rsp_cnt_q == '0)));
        state_d         = state_q;
        grant_d         = grant_q;
        gidx_d          = gidx_q;
        rr_ptr_d        = rr_ptr_q;
        rsp_cnt_d       = out_open ? cnt_dec : rsp_cnt_q;
        if (state_q == IDLE && |req_din_valid) begin
            state_d   = FWD;
            grant_d   = arb_gnt;
            gidx_d    = arb_idx;
            rsp_cnt_d = req_rsp_len[arb_idx*LEN_W +: LEN_W];
            rr_ptr_d  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end else if (done) begin
            state_d = IDLE;
            grant_d = '0;
        end else if (in_open && in_last) begin
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            rsp_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
        end
    end

    assign grant          = grant_q;
    assign busy           = state_q != IDLE;
    assign err_stray_dout = err_q;

`ifdef FRIET_ARB_STATS_EN
    logic [NUM_REQ*STATS_W-1:0] txn_count_q, txn_count_d;

    always_comb begin
        txn_count_d = txn_count_q;
        if (done) txn_count_d[gidx_q*STATS_W +: STATS_W] = txn_count_q[gidx_q*STATS_W +: STATS_W] + 1'b1;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) txn_count_q <= '0;
        else txn_count_q <= txn_count_d;
    end

    assign txn_count = txn_count_q;
`endif
endmodule

// File: tb/tb_friet_ae_stream_arbiter.sv
// tb_friet_ae_stream_arbiter: directed stimulus with a transaction-level model checked every cycle.
module tb_friet_ae_stream_arbiter;
    logic        clk = 1'b0;
    logic        arstn;
    logic [15:0] req_din;
    logic [1:0]  req_din_valid, req_din_last, req_din_ready, req_dout_valid, req_dout_ready, grant;
    logic [31:0] req_rsp_len;
    logic [7:0]  req_dout, core_din, core_dout;
    logic        core_din_valid, core_din_ready, core_dout_valid, core_dout_ready, busy, err_stray_dout;
`ifdef FRIET_ARB_STATS_EN
    logic [31:0] txn_count;
`endif

    friet_ae_stream_arbiter #(.NUM_REQ(2), .LEN_W(16)) dut (
        .clk(clk), .arstn(arstn),
        .req_din(req_din), .req_din_valid(req_din_valid), .req_din_last(req_din_last),
        .req_din_ready(req_din_ready), .req_rsp_len(req_rsp_len),
        .req_dout(req_dout), .req_dout_valid(req_dout_valid), .req_dout_ready(req_dout_ready),
        .core_din(core_din), .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
        .core_dout(core_dout), .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
        .grant(grant), .busy(busy), .err_stray_dout(err_stray_dout)
`ifdef FRIET_ARB_STATS_EN
        , .txn_count(txn_count)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0, dv0_pulses = 0;
    int m_own = -1, m_rem = 0, m_ptr = 0;
    bit m_in = 0, m_err = 0, own_ok;
    int m_txn[2] = '{0, 0};
    logic [1:0] e_g;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: owner index (-1 idle), input path open flag, remaining response beats.
    always @(negedge clk) begin
        if (!arstn) begin
            m_own = -1; m_rem = 0; m_ptr = 0; m_in = 0; m_err = 0; m_txn = '{0, 0};
        end
        own_ok = m_own >= 0;
        e_g = own_ok ? 2'b01 << m_own : 2'b00;
        chk("grant", grant, e_g);
        chk("busy", busy, own_ok);
        chk("err", err_stray_dout, m_err);
        chk("core_din_valid", core_din_valid, (own_ok && m_in) ? req_din_valid[m_own] : 1'b0);
        if (own_ok && m_in) chk("core_din", core_din, req_din[m_own*8 +: 8]);
        chk("req_din_ready", req_din_ready, (own_ok && m_in && core_din_ready) ? e_g : 2'b00);
        chk("req_dout_valid", req_dout_valid, (own_ok && core_dout_valid) ? e_g : 2'b00);
        chk("core_dout_ready", core_dout_ready, own_ok ? req_dout_ready[m_own] : 1'b0);
        chk("req_dout", req_dout, core_dout);
`ifdef FRIET_ARB_STATS_EN
        chk("txn_count", txn_count, {m_txn[1][15:0], m_txn[0][15:0]});
`endif
        if (req_dout_valid[0]) dv0_pulses++;
        if (arstn) begin
            if (m_own < 0) begin
                if (core_dout_valid) m_err = 1;
                if (req_din_valid != 2'b00) begin
                    for (int k = 0; k < 2; k++)
                        if (m_own < 0 && req_din_valid[(m_ptr + k) % 2]) m_own = (m_ptr + k) % 2;
                    m_rem = int'(req_rsp_len[m_own*16 +: 16]);
                    m_ptr = (m_own + 1) % 2;
                    m_in = 1;
                end
            end else begin
                if (core_dout_valid) begin
                    if (m_rem == 0) begin
                        if (m_in) m_err = 1;
                    end else m_rem--;
                end
                if (m_in && req_din_valid[m_own] && core_din_ready && req_din_last[m_own]) m_in = 0;
                if (!m_in && m_rem == 0) begin
                    m_txn[m_own]++;
                    m_own = -1;
                end
            end
        end
    end

    initial begin
        arstn = 0; req_din = 0; req_din_valid = 0; req_din_last = 0; req_dout_ready = 2'b11;
        req_rsp_len = 0; core_din_ready = 1; core_dout_valid = 0; core_dout = 0;
        repeat (2) cyc();
        chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_err", err_stray_dout, 0);
        arstn = 1; cyc();
        // Single requester, 5 bytes in, 5 beats out lagging by one cycle.
        req_rsp_len[15:0] = 16'd5; req_din[7:0] = 8'h10; req_din_valid = 2'b01;
        cyc(); chk("t1_grant", grant, 2'b01);
        for (int i = 0; i < 6; i++) begin
            req_din_valid = (i < 5) ? 2'b01 : 2'b00;
            req_din[7:0] = 8'h10 + 8'(i);
            req_din_last = (i == 4) ? 2'b01 : 2'b00;
            core_dout_valid = i >= 1; core_dout = 8'hA0 + 8'(i);
            req_dout_ready = (i % 2 == 1) ? 2'b11 : 2'b10;
            cyc();
        end
        core_dout_valid = 0; req_din_last = 0; req_dout_ready = 2'b11;
        chk("t1_grant_end", grant, 0); chk("t1_busy_end", busy, 0); chk("t1_beats", dv0_pulses, 5);
        // Contention from reset: 0, then 1, then 0 again.
        arstn = 0; cyc(); arstn = 1; cyc();
        req_rsp_len = 0; req_din_last = 2'b11; req_din_valid = 2'b11; req_din = 16'h2221;
        cyc(); chk("t2_first", grant, 2'b01);
        cyc(); chk("t2_gap", grant, 2'b00);
        cyc(); chk("t2_second", grant, 2'b10);
        cyc(); cyc(); chk("t2_third", grant, 2'b01);
        cyc(); req_din_valid = 0; req_din_last = 0;
        // Zero-length response with one core stall.
        req_din_valid = 2'b01; req_din[7:0] = 8'h30;
        cyc(); chk("t3_grant", grant, 2'b01);
        for (int i = 0; i < 4; i++) begin
            req_din[7:0] = 8'h30 + 8'((i < 2) ? i : i - 1);
            req_din_last = (i == 3) ? 2'b01 : 2'b00;
            core_din_ready = i != 1;
            cyc();
        end
        req_din_valid = 0; req_din_last = 0; core_din_ready = 1;
        chk("t3_idle", busy, 0); chk("t3_err", err_stray_dout, 0);
        // Last byte and final beat coincide; req0 waits for the next grant.
        req_rsp_len = {16'd2, 16'd0}; req_din = 16'h4050; req_din_valid = 2'b11; req_din_last = 2'b01;
        cyc(); chk("t4_grant", grant, 2'b10);
        for (int i = 0; i < 2; i++) begin
            req_din[15:8] = 8'h41 + 8'(i);
            req_din_last[1] = i == 1;
            core_dout_valid = 1; core_dout = 8'hC0 + 8'(i);
            cyc();
        end
        core_dout_valid = 0;
        chk("t4_idle", busy, 0); chk("t4_grant0", grant, 0);
        cyc(); chk("t4_next", grant, 2'b01);
        cyc(); req_din_valid = 0; req_din_last = 0;
        chk("t4_done", busy, 0); chk("t4_err", err_stray_dout, 0);
        // Stray beat while idle, then reset in the middle of a transaction.
        core_dout_valid = 1; core_dout = 8'hEE; #1;
        chk("t5_no_valid", req_dout_valid, 0);
        cyc(); core_dout_valid = 0; chk("t5_err", err_stray_dout, 1);
        cyc(); chk("t5_sticky", err_stray_dout, 1);
        req_din_valid = 2'b01; req_rsp_len[15:0] = 16'd3;
        cyc(); chk("t5_grant", grant, 2'b01);
        cyc(); arstn = 0; #1;
        chk("t5_rst_grant", grant, 0); chk("t5_rst_busy", busy, 0); chk("t5_rst_err", err_stray_dout, 0);
        req_din_valid = 0; cyc(); arstn = 1; cyc();
        // Three transactions for req1, one for req0.
        req_rsp_len = 0; req_din_last = 2'b11; req_din_valid = 2'b10;
        repeat (6) cyc();
        req_din_valid = 2'b01;
        repeat (2) cyc();
        req_din_valid = 0; req_din_last = 0;
        chk("t6_idle", busy, 0);
`ifdef FRIET_ARB_STATS_EN
        chk("t6_stats", txn_count, {16'd3, 16'd1});
`endif
        cyc();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/friet_ae_stream_arbiter.md
Name: friet_ae_stream_arbiter

Overview:
- Round-robin arbiter that shares one 8-bit Friet AE stream core (friet_ae_8_bits) between NUM_REQ requesters.
- Grants whole transactions: one requester's full input packet plus its expected response bytes. It then releases and re-arbitrates.
- Sits between the requester stream ports and the core's din/dout handshake ports.
- Purely a routing/sequencing block; it never inspects payload bytes.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- LEN_W, 16, width of the per-transaction response byte count.

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- req_din  in  NUM_REQ*8  flattened request bytes; requester i at [8i+7:8i]
- req_din_valid  in  NUM_REQ  byte valid per requester
- req_din_last  in  NUM_REQ  marks the final input byte of the transaction
- req_din_ready  out  NUM_REQ  byte accepted
- req_rsp_len  in  NUM_REQ*LEN_W  expected response bytes; sampled at grant
- req_dout  out  8  shared response byte, broadcast to all requesters
- req_dout_valid  out  NUM_REQ  response valid, asserted only toward the granted requester
- req_dout_ready  in  NUM_REQ  response ready per requester
- core_din  out  8  to core din
- core_din_valid  out  1  to core din_valid
- core_din_ready  in  1  from core din_ready
- core_dout  in  8  from core dout
- core_dout_valid  in  1  from core dout_valid
- core_dout_ready  out  1  to core dout_ready
- grant  out  NUM_REQ  registered one-hot grant; 0 when idle
- busy  out  1  high in any state other than IDLE
- err_stray_dout  out  1  sticky; set when core_dout_valid=1 while not in FWD or DRAIN

Behaviour:
- Reset values: grant=0, busy=0, err_stray_dout=0, round-robin pointer=0, state=IDLE, counters=0.
- The reset is asynchronous; all state returns to these values immediately, including mid-transaction. In-flight bytes are dropped.
- States:
  - IDLE: if any req_din_valid is high, pick the first requester at or after rr_ptr, wrapping modulo NUM_REQ.
    - Next cycle: grant=onehot(g), rsp_cnt=req_rsp_len[g], rr_ptr=(g+1) mod NUM_REQ, state=FWD.
    - Arbitration latency is one cycle; no byte is accepted in the IDLE cycle.
  - FWD: input and output paths both open.
    - core_din=req_din[g]; core_din_valid=req_din_valid[g].
    - req_din_ready[g]=core_din_ready; all other readys 0.
    - A byte transfers when valid&ready. A transfer with req_din_last[g]=1 closes the input path.
    - If rsp_cnt is then 0 (after any same-cycle decrement), go to IDLE; otherwise go to DRAIN.
  - DRAIN: input path closed (core_din_valid=0, all req_din_ready=0). Output path stays open.
  - Output path (FWD and DRAIN):
    - req_dout=core_dout; req_dout_valid[g]=core_dout_valid; core_dout_ready=req_dout_ready[g].
    - rsp_cnt decrements by 1 on each core_dout_valid beat (the core emits registered beats independently of ready).
    - rsp_cnt saturates at 0. A beat arriving at rsp_cnt=0 during FWD sets err_stray_dout.
    - When rsp_cnt reaches 0 in DRAIN, go to IDLE the following cycle.
- Simultaneous events:
  - Final input byte and final response beat in the same FWD cycle: go directly to IDLE.
  - req_rsp_len=0: release immediately after the last input byte.
- Outside FWD/DRAIN: core_dout_ready=0, core_din_valid=0, all req_dout_valid=0.
- Requesters that are not granted see ready=0 and valid=0. Their valid may stay asserted; it is not lost.
- Fairness: the requester granted last has lowest priority next time. With all requesters continuously requesting, every requester is served within NUM_REQ transactions.

Optional Feature:
- Macro: FRIET_ARB_STATS_EN.
- When defined, adds output txn_count [NUM_REQ*16-1:0].
  - One 16-bit counter per requester, incremented on each transaction completion (entry into IDLE from FWD/DRAIN).
  - Wraps 0xFFFF→0; reset to 0 by arstn.
- When undefined, the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package friet_ae_arb_pkg holds:
  - state encoding localparams: IDLE=2'd0, FWD=2'd1, DRAIN=2'd2;
  - the default LEN_W;
  - the stats counter width (16).
- One sub-module: friet_rr_arbiter. It is combinational.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant and its index.
  - Used by the IDLE state and reusable elsewhere.

Test Plan:
- Single requester: req0 sends 5 bytes (last on byte 5), rsp_len=5, core echoes 5 beats. Expect grant=01 one cycle after valid, 5 bytes on core_din, 5 req_dout_valid[0] pulses, then grant=0 and busy=0.
- Contention: req0 and req1 both valid in the same cycle from reset. Expect req0 served first. Then, with both still requesting, req1 served next and req0 after that.
- Zero-length response: rsp_len=0, 3 input bytes. Expect return to IDLE the cycle after the last byte; err_stray_dout stays 0.
- Same-cycle finish: the last input byte and the final response beat coincide. Expect direct FWD→IDLE with no DRAIN cycle; the next grant is issued the cycle after IDLE.
- Stray output: a core_dout_valid pulse while IDLE. Expect err_stray_dout=1 (sticky) and no req_dout_valid asserted. Assert arstn low mid-FWD: expect grant=0, busy=0, err=0 immediately.
- With FRIET_ARB_STATS_EN: 3 transactions for req1, 1 for req0. Expect txn_count = {16'd3, 16'd1}.
